// File: rtl/sipo_pkg.sv
// -----------------------------------------------------------------------------
// sipo_pkg
// Shared definitions for the serial-to-parallel deserializer:
//   - state_t      : receive FSM states (PARITY is only entered when the
//                    design is built with PARITY_EN defined)
//   - cnt_width()  : bit-counter width for a given word width, sized so the
//                    counter can hold the value WIDTH itself
//   - DEFAULT_*    : the default word width and its matching counter width
// -----------------------------------------------------------------------------
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/sipo_deserializer_out_reg.sv
// -----------------------------------------------------------------------------
// sipo_out_reg
// One-deep output register of the deserializer. Owns the valid/ready
// handshake and decides whether a freshly completed word is accepted or
// dropped (overrun).
//
// Optional feature macro: PARITY_EN (adds load_perr / parity_err).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         a frame completed this cycle
//   load_word    the completed word
//   load_perr    parity result of the completed frame (PARITY_EN only)
//   word_ready   consumer accepts word_out this cycle
//   word_out     held word
//   word_valid   word_out holds an unconsumed word
//   parity_err   parity result registered with word_out (PARITY_EN only)
//   overrun      one-cycle pulse when a completed word had to be dropped
// -----------------------------------------------------------------------------
module sipo_out_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
`ifdef PARITY_EN
    input  logic             load_perr,
    output logic             parity_err,
`endif
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             overrun
);

    logic reg_free;

    // The register can take a new word if it is empty, or if the consumer is
    // draining the current word in this very cycle.
    always_comb begin
        reg_free = !word_valid || word_ready;
    end

    // A completion into a free register reloads it and keeps valid high even
    // if the old word is consumed at the same edge. A completion into a full,
    // stalled register leaves word_out untouched and raises overrun for
    // exactly the cycle in which word_valid would otherwise have risen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun <= load && !reg_free;
            if (load && reg_free) begin
                word_out   <= load_word;
                word_valid <= 1'b1;
`ifdef PARITY_EN
                parity_err <= load_perr;
`endif
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// -----------------------------------------------------------------------------
// sipo_deserializer
// Serial-to-parallel receive stage. Collects a sync-framed bit stream,
// rebuilds WIDTH-bit words and hands them to a one-deep valid/ready output
// register (sipo_out_reg).
//
// Optional feature macro: PARITY_EN -- each frame carries one trailing
// even-parity bit and the parity_err output exists.
//
// Parameters:
//   WIDTH      data bits per frame (2..32)
//   LSB_FIRST  1: first received bit -> word_out[0]
//              0: first received bit -> word_out[WIDTH-1]
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   sync         frame-start strobe (also aborts a frame in progress)
//   bit_in       serial data, qualified by bit_valid
//   bit_valid    bit_in carries a bit this cycle
//   word_out     assembled word
//   word_valid   word_out holds an unconsumed word
//   word_ready   consumer accepts word_out
//   busy         a frame is in progress
//   overrun      one-cycle pulse when a completed word is dropped
//   parity_err   even-parity failure of word_out (PARITY_EN only)
// -----------------------------------------------------------------------------
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
`ifdef PARITY_EN
    output logic             parity_err,
`endif
    output logic             overrun
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic             last_data;
    logic             frame_done;
    logic [WIDTH-1:0] done_word;
`ifdef PARITY_EN
    logic             par_acc;
    logic             done_perr;
`endif

    // Shift direction decides which end of the word the first bit ends up in:
    // shifting right parks the first bit at [0] after WIDTH shifts, shifting
    // left parks it at [WIDTH-1].
    always_comb begin
        shift_next = shift_reg;
        if (LSB_FIRST) begin
            shift_next = {bit_in, shift_reg[WIDTH-1:1]};
        end else begin
            shift_next = {shift_reg[WIDTH-2:0], bit_in};
        end
    end

    // Frame completion. A sync in the same cycle always wins and suppresses
    // the word. Without parity the word completes on the last data bit, so
    // the freshly shifted value is delivered; with parity the data is already
    // sitting in the shift register when the parity bit arrives.
    always_comb begin
        last_data = (state == SHIFT) && bit_valid && (bit_cnt == LAST_IDX);
`ifdef PARITY_EN
        frame_done = !sync && bit_valid && (state == PARITY);
        done_word  = shift_reg;
        done_perr  = par_acc ^ bit_in;
`else
        frame_done = !sync && last_data;
        done_word  = shift_next;
`endif
    end

    // Datapath: shift register, bit counter and running parity. A sync
    // restarts everything, and the bit arriving with it counts as bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
`ifdef PARITY_EN
            par_acc   <= 1'b0;
`endif
        end else if (sync) begin
            bit_cnt <= bit_valid ? CW'(1) : '0;
            if (bit_valid) begin
                shift_reg <= shift_next;
            end
`ifdef PARITY_EN
            par_acc <= bit_valid && bit_in;
`endif
        end else if ((state == SHIFT) && bit_valid) begin
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt + CW'(1);
`ifdef PARITY_EN
            par_acc   <= par_acc ^ bit_in;
`endif
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic. sync takes priority in every state.
    always_comb begin
        state_next = state;
        if (sync) begin
            state_next = SHIFT;
        end else begin
            case (state)
                SHIFT: begin
                    if (last_data) begin
`ifdef PARITY_EN
                        state_next = PARITY;
`else
                        state_next = IDLE;
`endif
                    end
                end
                PARITY: begin
                    if (bit_valid) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        busy = (state != IDLE);
    end

    sipo_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (frame_done),
        .load_word  (done_word),
`ifdef PARITY_EN
        .load_perr  (done_perr),
        .parity_err (parity_err),
`endif
        .word_ready (word_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .overrun    (overrun)
    );

endmodule
